// File: rtl/hazard_scheduler.sv
// hazard_scheduler: stall/flush scheduler for the 5-stage MIPS core.
// It covers the hazards that forwarding cannot resolve: load-use,
// branch operands compared in ID, taken-branch/jump squash, and
// occupancy of the multi-cycle multiply/divide unit (MDU).
// Optional build macro: HAZARD_PERF_CNT_EN adds a 32-bit stall_cnt
// output that counts stalled cycles; without it the port is absent.
module hazard_scheduler #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] IFID_Rs,
    input  logic [4:0] IFID_Rt,
    input  logic       IFID_is_branch,
    input  logic       IFID_uses_hilo,
    input  logic [1:0] IFID_mdu_op,
    input  logic       IDEX_mem_read,
    input  logic       IDEX_reg_write,
    input  logic [4:0] IDEX_Rd,
    input  logic       branch_taken,
    input  logic       jump,
    output logic       PC_write,
    output logic       IFID_write,
    output logic       IFID_flush,
    output logic       IDEX_flush,
    output logic       mdu_busy,
    output logic       mdu_done
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    // Branch-after-load needs a second stall cycle while the load reaches MEM.
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_BR_WAIT = 1'b1;

    // The counter is loaded with N-1 so the done pulse lands on the Nth busy cycle.
    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 1);

    logic [0:0] r_state;
    logic [7:0] r_mcnt;
    logic       r_mdu_busy;
    logic       r_mdu_done;

    logic w_rd_match;
    logic w_load_use;
    logic w_br_alu;
    logic w_br_load;
    logic w_mdu_req;
    logic w_mdu_hz;
    logic w_stall;
    logic w_mdu_start;

    // $0 is never a real producer, so a zero destination never creates a hazard.
    assign w_rd_match  = (IDEX_Rd != 5'd0) &&
                         ((IDEX_Rd == IFID_Rs) || (IDEX_Rd == IFID_Rt));
    assign w_load_use  = IDEX_mem_read & w_rd_match;
    assign w_br_alu    = IFID_is_branch & IDEX_reg_write & ~IDEX_mem_read & w_rd_match;
    assign w_br_load   = IFID_is_branch & w_load_use;
    // Opcode 11 is reserved and behaves like "no MDU operation".
    assign w_mdu_req   = (IFID_mdu_op == 2'b01) || (IFID_mdu_op == 2'b10);
    // On the done cycle the results are ready, so HI/LO readers and a new
    // MDU op may proceed without waiting another cycle.
    assign w_mdu_hz    = r_mdu_busy & (IFID_uses_hilo | w_mdu_req) & ~r_mdu_done;
    assign w_stall     = w_load_use | w_br_alu | (r_state == ST_BR_WAIT) | w_mdu_hz;
    // A stalled op must not start the MDU; it retries once the stall clears.
    assign w_mdu_start = w_mdu_req & ~w_stall & (~r_mdu_busy | r_mdu_done);

    assign mdu_busy = r_mdu_busy;
    assign mdu_done = r_mdu_done;

    // Pipeline write enables and flushes; stall outranks any redirect, and reset holds a bubble.
    always_comb begin
        PC_write   = 1'b1;
        IFID_write = 1'b1;
        IFID_flush = 1'b0;
        IDEX_flush = 1'b0;
        if (!rst_n) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IFID_flush = 1'b0;
            IDEX_flush = 1'b1;
        end else if (w_stall) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IFID_flush = 1'b0;
            IDEX_flush = 1'b1;
        end else begin
            IFID_flush = branch_taken | jump;
        end
    end

    // Branch-wait FSM: one extra stall cycle after a branch that depends on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    r_state <= w_br_load ? ST_BR_WAIT : ST_IDLE;
                ST_BR_WAIT: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    // MDU occupancy tracker: load on start, count down, pulse done on the last busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdu_busy <= 1'b0;
            r_mdu_done <= 1'b0;
            r_mcnt     <= 8'd0;
        end else if (w_mdu_start) begin
            r_mdu_busy <= 1'b1;
            r_mdu_done <= 1'b0;
            r_mcnt     <= (IFID_mdu_op == 2'b01) ? MULT_LOAD : DIV_LOAD;
        end else if (r_mdu_done) begin
            r_mdu_busy <= 1'b0;
            r_mdu_done <= 1'b0;
            r_mcnt     <= 8'd0;
        end else if (r_mdu_busy) begin
            if (r_mcnt == 8'd1) begin
                r_mdu_done <= 1'b1;
                r_mcnt     <= 8'd0;
            end else begin
                r_mcnt <= r_mcnt - 8'd1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    assign stall_cnt = r_stall_cnt;

    // Performance counter of stalled cycles; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Testbench for hazard_scheduler: directed scenarios followed by a
// randomized run checked against a cycle-level behavioural model.
module tb_hazard_scheduler;

    localparam int MC = 4;
    localparam int DC = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] IFID_Rs = '0;
    logic [4:0] IFID_Rt = '0;
    logic       IFID_is_branch = 1'b0;
    logic       IFID_uses_hilo = 1'b0;
    logic [1:0] IFID_mdu_op = '0;
    logic       IDEX_mem_read = 1'b0;
    logic       IDEX_reg_write = 1'b0;
    logic [4:0] IDEX_Rd = '0;
    logic       branch_taken = 1'b0;
    logic       jump = 1'b0;
    logic       PC_write;
    logic       IFID_write;
    logic       IFID_flush;
    logic       IDEX_flush;
    logic       mdu_busy;
    logic       mdu_done;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: pending branch-wait cycle, remaining MDU busy cycles
    // (done is the last of them), and the number of stalled cycles.
    bit          m_brwait = 1'b0;
    int          m_left = 0;
    int unsigned m_stall_cnt = 0;

    hazard_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .IFID_Rs(IFID_Rs),
        .IFID_Rt(IFID_Rt),
        .IFID_is_branch(IFID_is_branch),
        .IFID_uses_hilo(IFID_uses_hilo),
        .IFID_mdu_op(IFID_mdu_op),
        .IDEX_mem_read(IDEX_mem_read),
        .IDEX_reg_write(IDEX_reg_write),
        .IDEX_Rd(IDEX_Rd),
        .branch_taken(branch_taken),
        .jump(jump),
        .PC_write(PC_write),
        .IFID_write(IFID_write),
        .IFID_flush(IFID_flush),
        .IDEX_flush(IDEX_flush),
        .mdu_busy(mdu_busy),
        .mdu_done(mdu_done)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit model_load_use();
        return IDEX_mem_read && IDEX_Rd != 0 && (IDEX_Rd == IFID_Rs || IDEX_Rd == IFID_Rt);
    endfunction

    function automatic bit model_mdu_req();
        return IFID_mdu_op == 2'd1 || IFID_mdu_op == 2'd2;
    endfunction

    function automatic bit model_stall();
        bit br_alu;
        bit mdu_wait;
        br_alu = IFID_is_branch && IDEX_reg_write && !IDEX_mem_read && IDEX_Rd != 0 &&
                 (IDEX_Rd == IFID_Rs || IDEX_Rd == IFID_Rt);
        mdu_wait = (m_left > 1) && (IFID_uses_hilo || model_mdu_req());
        return model_load_use() || br_alu || m_brwait || mdu_wait;
    endfunction

    task automatic model_reset();
        m_brwait    = 1'b0;
        m_left      = 0;
        m_stall_cnt = 0;
    endtask

    task automatic clear_inputs();
        IFID_Rs = '0; IFID_Rt = '0; IFID_is_branch = 1'b0; IFID_uses_hilo = 1'b0;
        IFID_mdu_op = '0; IDEX_mem_read = 1'b0; IDEX_reg_write = 1'b0; IDEX_Rd = '0;
        branch_taken = 1'b0; jump = 1'b0;
    endtask

    // Advance one clock and the reference model with the pre-edge inputs.
    task automatic tick();
        bit st;
        bit br_load;
        bit start;
        int n;
        st      = model_stall();
        br_load = IFID_is_branch && model_load_use();
        start   = model_mdu_req() && !st && (m_left <= 1);
        n       = (IFID_mdu_op == 2'd1) ? MC : DC;
        @(posedge clk);
        if (rst_n) begin
            if (st) m_stall_cnt++;
            m_brwait = !m_brwait && br_load;
            if (start) m_left = n;
            else if (m_left > 0) m_left--;
        end
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        jump = 1'b1;
        @(negedge clk);
        checks++; if (PC_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_pcw: got %b want 0", PC_write); end
        checks++; if (IFID_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_ifidw: got %b want 0", IFID_write); end
        checks++; if (IFID_flush !== 1'b0) begin errors++; $display("[TB] FAIL reset_ifidflush: got %b want 0", IFID_flush); end
        checks++; if (IDEX_flush !== 1'b1) begin errors++; $display("[TB] FAIL reset_idexflush: got %b want 1", IDEX_flush); end
        checks++; if (mdu_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", mdu_busy); end
        checks++; if (mdu_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", mdu_done); end
        clear_inputs();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (PC_write !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_pcw: got %b want 1", PC_write); end
        tick();
    endtask

    task automatic test_load_use();
        IDEX_mem_read = 1'b1; IDEX_Rd = 5'd2; IFID_Rs = 5'd2; IFID_Rt = 5'd4;
        @(negedge clk);
        checks++; if (PC_write !== 1'b0) begin errors++; $display("[TB] FAIL lu_pcw: got %b want 0", PC_write); end
        checks++; if (IFID_write !== 1'b0) begin errors++; $display("[TB] FAIL lu_ifidw: got %b want 0", IFID_write); end
        checks++; if (IDEX_flush !== 1'b1) begin errors++; $display("[TB] FAIL lu_idexflush: got %b want 1", IDEX_flush); end
        tick();
        IDEX_mem_read = 1'b0; IDEX_Rd = 5'd0;
        @(negedge clk);
        checks++; if (PC_write !== 1'b1) begin errors++; $display("[TB] FAIL lu_after_pcw: got %b want 1", PC_write); end
        checks++; if (IDEX_flush !== 1'b0) begin errors++; $display("[TB] FAIL lu_after_idexflush: got %b want 0", IDEX_flush); end
        tick();
        IDEX_mem_read = 1'b1; IDEX_Rd = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0;
        @(negedge clk);
        checks++; if (PC_write !== 1'b1) begin errors++; $display("[TB] FAIL lu_rd0_pcw: got %b want 1", PC_write); end
        tick();
        clear_inputs();
    endtask

    task automatic test_branch_load();
        IDEX_mem_read = 1'b1; IDEX_Rd = 5'd5; IFID_Rs = 5'd5; IFID_Rt = 5'd6;
        IFID_is_branch = 1'b1; branch_taken = 1'b1;
        @(negedge clk);
        checks++; if (PC_write !== 1'b0) begin errors++; $display("[TB] FAIL brld1_pcw: got %b want 0", PC_write); end
        checks++; if (IFID_flush !== 1'b0) begin errors++; $display("[TB] FAIL brld1_ifidflush: got %b want 0", IFID_flush); end
        tick();
        IDEX_mem_read = 1'b0; IDEX_Rd = 5'd0;
        @(negedge clk);
        checks++; if (PC_write !== 1'b0) begin errors++; $display("[TB] FAIL brld2_pcw: got %b want 0", PC_write); end
        checks++; if (IFID_flush !== 1'b0) begin errors++; $display("[TB] FAIL brld2_ifidflush: got %b want 0", IFID_flush); end
        checks++; if (IDEX_flush !== 1'b1) begin errors++; $display("[TB] FAIL brld2_idexflush: got %b want 1", IDEX_flush); end
        tick();
        @(negedge clk);
        checks++; if (PC_write !== 1'b1) begin errors++; $display("[TB] FAIL brld3_pcw: got %b want 1", PC_write); end
        checks++; if (IFID_flush !== 1'b1) begin errors++; $display("[TB] FAIL brld3_ifidflush: got %b want 1", IFID_flush); end
        tick();
        clear_inputs();
    endtask

    task automatic test_branch_alu();
        IDEX_reg_write = 1'b1; IDEX_Rd = 5'd7; IFID_Rs = 5'd7; IFID_Rt = 5'd0;
        IFID_is_branch = 1'b1;
        @(negedge clk);
        checks++; if (PC_write !== 1'b0) begin errors++; $display("[TB] FAIL bralu1_pcw: got %b want 0", PC_write); end
        tick();
        IDEX_reg_write = 1'b0; IDEX_Rd = 5'd0; branch_taken = 1'b1;
        @(negedge clk);
        checks++; if (PC_write !== 1'b1) begin errors++; $display("[TB] FAIL bralu2_pcw: got %b want 1", PC_write); end
        checks++; if (IFID_flush !== 1'b1) begin errors++; $display("[TB] FAIL bralu2_ifidflush: got %b want 1", IFID_flush); end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++; if (IFID_flush !== 1'b0) begin errors++; $display("[TB] FAIL bralu3_ifidflush: got %b want 0", IFID_flush); end
        tick();
    endtask

    task automatic test_mult();
        IFID_mdu_op = 2'd1;
        @(negedge clk);
        checks++; if (mdu_busy !== 1'b0) begin errors++; $display("[TB] FAIL mult_pre_busy: got %b want 0", mdu_busy); end
        checks++; if (PC_write !== 1'b1) begin errors++; $display("[TB] FAIL mult_pre_pcw: got %b want 1", PC_write); end
        tick();
        IFID_mdu_op = 2'd0; IFID_uses_hilo = 1'b1;
        for (int c = 0; c < MC; c++) begin
            logic last;
            last = (c == MC - 1);
            @(negedge clk);
            checks++; if (mdu_busy !== 1'b1) begin errors++; $display("[TB] FAIL mult_busy c%0d: got %b want 1", c, mdu_busy); end
            checks++; if (mdu_done !== last) begin errors++; $display("[TB] FAIL mult_done c%0d: got %b want %b", c, mdu_done, last); end
            checks++; if (PC_write !== last) begin errors++; $display("[TB] FAIL mflo_pcw c%0d: got %b want %b", c, PC_write, last); end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        checks++; if (mdu_busy !== 1'b0) begin errors++; $display("[TB] FAIL mult_post_busy: got %b want 0", mdu_busy); end
        checks++; if (mdu_done !== 1'b0) begin errors++; $display("[TB] FAIL mult_post_done: got %b want 0", mdu_done); end
        tick();
    endtask

    task automatic test_back_to_back();
        IFID_mdu_op = 2'd2;
        tick();
        IFID_mdu_op = 2'd1;
        for (int c = 0; c < DC; c++) begin
            logic last;
            last = (c == DC - 1);
            @(negedge clk);
            checks++; if (mdu_done !== last) begin errors++; $display("[TB] FAIL div_done c%0d: got %b want %b", c, mdu_done, last); end
            checks++; if (PC_write !== last) begin errors++; $display("[TB] FAIL div_mult_pcw c%0d: got %b want %b", c, PC_write, last); end
            tick();
        end
        IFID_mdu_op = 2'd0;
        @(negedge clk);
        checks++; if (mdu_busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy: got %b want 1", mdu_busy); end
        checks++; if (mdu_done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done: got %b want 0", mdu_done); end
        for (int c = 0; c < MC; c++) tick();
        @(negedge clk);
        checks++; if (mdu_busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end_busy: got %b want 0", mdu_busy); end
        tick();
    endtask

    task automatic test_reset_abort();
        IFID_mdu_op = 2'd2;
        tick();
        IFID_mdu_op = 2'd0;
        for (int c = 0; c < DC - 11; c++) tick();
        @(negedge clk);
        checks++; if (mdu_busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_pre_busy: got %b want 1", mdu_busy); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (mdu_busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b want 0", mdu_busy); end
        checks++; if (IDEX_flush !== 1'b1) begin errors++; $display("[TB] FAIL abort_idexflush: got %b want 1", IDEX_flush); end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            checks++; if (mdu_done !== 1'b0 || mdu_busy !== 1'b0) begin
                errors++; $display("[TB] FAIL abort_after c%0d: busy %b done %b want 0 0", c, mdu_busy, mdu_done);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bit st;
            bit redir;
            IFID_Rs        = 5'($urandom_range(0, 3));
            IFID_Rt        = 5'($urandom_range(0, 3));
            IDEX_Rd        = 5'($urandom_range(0, 3));
            IDEX_mem_read  = ($urandom_range(0, 2) == 0);
            IDEX_reg_write = ($urandom_range(0, 1) == 0);
            IFID_is_branch = ($urandom_range(0, 3) == 0);
            IFID_uses_hilo = ($urandom_range(0, 3) == 0);
            IFID_mdu_op    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            branch_taken   = ($urandom_range(0, 3) == 0);
            jump           = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            st    = model_stall();
            redir = !st && (branch_taken || jump);
            checks++; if (PC_write !== !st) begin errors++; $display("[TB] FAIL rnd_pcw c%0d: got %b want %b", c, PC_write, !st); end
            checks++; if (IFID_write !== !st) begin errors++; $display("[TB] FAIL rnd_ifidw c%0d: got %b want %b", c, IFID_write, !st); end
            checks++; if (IDEX_flush !== st) begin errors++; $display("[TB] FAIL rnd_idexflush c%0d: got %b want %b", c, IDEX_flush, st); end
            checks++; if (IFID_flush !== redir) begin errors++; $display("[TB] FAIL rnd_ifidflush c%0d: got %b want %b", c, IFID_flush, redir); end
            checks++; if (mdu_busy !== (m_left > 0)) begin errors++; $display("[TB] FAIL rnd_busy c%0d: got %b want %b", c, mdu_busy, m_left > 0); end
            checks++; if (mdu_done !== (m_left == 1)) begin errors++; $display("[TB] FAIL rnd_done c%0d: got %b want %b", c, mdu_done, m_left == 1); end
`ifdef HAZARD_PERF_CNT_EN
            checks++; if (stall_cnt !== m_stall_cnt) begin errors++; $display("[TB] FAIL rnd_stall_cnt c%0d: got %0d want %0d", c, stall_cnt, m_stall_cnt); end
`endif
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load();
        test_branch_alu();
        test_mult();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
